// File: rtl/avalon_sdr_writer.sv
// Avalon-MM write master: streams a captured result buffer into SDRAM as
// 16-bit words, low halfword of each 32-bit element first, byte-addressed.
module avalon_sdr_writer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BUF_W  = 2048,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clkin,
  input  logic              sdr_reset,
  input  logic              sdr_writestart,
  input  logic [ADDR_W-1:0] sdr_baseaddr,
  input  logic [29:0]       sdr_nelems,
  input  logic [BUF_W-1:0]  sdr_writedata,
  output logic              sdr_writeend,
  output logic              sdr_busy,
  output logic              avm_m1_write,
  output logic [ADDR_W-1:0] avm_m1_address,
  output logic [DATA_W-1:0] avm_m1_writedata,
  output logic [1:0]        avm_m1_byteenable,
  input  logic              avm_m1_waitrequest
);

  localparam int unsigned MAX_ELEMS = BUF_W / 32;
  localparam int unsigned K_W       = $clog2(BUF_W / DATA_W);
  localparam int unsigned NW_W      = K_W + 1;
  localparam int unsigned IDX_W     = K_W + 4;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [NW_W-1:0]     nw_q, nw_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BUF_W-1:0]    data_q, data_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic                writeend_q, writeend_d;
  logic                busy_q, busy_d;

  logic [29:0]         nel_clamp_c;
  logic [NW_W-1:0]     nw_start_c;
  logic                last_c;
  logic [IDX_W-1:0]    bit_idx_c;

  // State and registered outputs
  always_ff @(posedge clkin or posedge sdr_reset) begin
    if (sdr_reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      nw_q       <= '0;
      base_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 2'b00;
      writeend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      nw_q       <= nw_d;
      base_q     <= base_d;
      data_q     <= data_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      writeend_q <= writeend_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, word sequencing and output staging
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    nw_d       = nw_q;
    base_d     = base_q;
    data_d     = data_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    bit_idx_c  = '0;

    nel_clamp_c = (sdr_nelems > 30'(MAX_ELEMS)) ? 30'(MAX_ELEMS) : sdr_nelems;
    nw_start_c  = NW_W'({nel_clamp_c, 1'b0});
    last_c      = ({1'b0, k_q} == (nw_q - NW_W'(1)));

    case (state_q)
      IDLE, DONE: begin
        if (sdr_writestart) begin
          base_d = sdr_baseaddr;
          data_d = sdr_writedata;
          nw_d   = nw_start_c;
          k_d    = '0;
          if (nw_start_c == '0) begin
            state_d = DONE;
            write_d = 1'b0;
            be_d    = 2'b00;
          end else begin
            state_d = WRITE;
            write_d = 1'b1;
            addr_d  = sdr_baseaddr;
            wdata_d = sdr_writedata[DATA_W-1:0];
            be_d    = 2'b11;
          end
        end
      end
      WRITE: begin
        // Advance only on acceptance; a stall leaves every output untouched
        if (!avm_m1_waitrequest) begin
          if (last_c) begin
            state_d = DONE;
            write_d = 1'b0;
            be_d    = 2'b00;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            k_d       = k_q + K_W'(1);
            bit_idx_c = {k_d, 4'b0000};
            addr_d    = base_q + ADDR_W'({k_d, 1'b0});
            wdata_d   = data_q[bit_idx_c +: DATA_W];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == WRITE);
    writeend_d = (state_d == DONE);
  end

  assign sdr_writeend      = writeend_q;
  assign sdr_busy          = busy_q;
  assign avm_m1_write      = write_q;
  assign avm_m1_address    = addr_q;
  assign avm_m1_writedata  = wdata_q;
  assign avm_m1_byteenable = be_q;

endmodule

// File: tb/tb_avalon_sdr_writer.sv
// Directed bench for avalon_sdr_writer: checks write sequencing, stalls,
// clamping, address wrap, reset abandonment and restart from DONE.
module tb_avalon_sdr_writer;

  logic          clkin = 1'b0;
  logic          sdr_reset;
  logic          sdr_writestart;
  logic [31:0]   sdr_baseaddr;
  logic [29:0]   sdr_nelems;
  logic [2047:0] sdr_writedata;
  logic          sdr_writeend;
  logic          sdr_busy;
  logic          avm_m1_write;
  logic [31:0]   avm_m1_address;
  logic [15:0]   avm_m1_writedata;
  logic [1:0]    avm_m1_byteenable;
  logic          avm_m1_waitrequest;

  int errors = 0;
  int checks = 0;

  logic [31:0] acc_addr[$];
  logic [15:0] acc_data[$];

  avalon_sdr_writer dut (
    .clkin              (clkin),
    .sdr_reset          (sdr_reset),
    .sdr_writestart     (sdr_writestart),
    .sdr_baseaddr       (sdr_baseaddr),
    .sdr_nelems         (sdr_nelems),
    .sdr_writedata      (sdr_writedata),
    .sdr_writeend       (sdr_writeend),
    .sdr_busy           (sdr_busy),
    .avm_m1_write       (avm_m1_write),
    .avm_m1_address     (avm_m1_address),
    .avm_m1_writedata   (avm_m1_writedata),
    .avm_m1_byteenable  (avm_m1_byteenable),
    .avm_m1_waitrequest (avm_m1_waitrequest)
  );

  always #5 clkin = ~clkin;

  // Log every word the slave accepts
  always @(posedge clkin) begin
    if (avm_m1_write && !avm_m1_waitrequest) begin
      acc_addr.push_back(avm_m1_address);
      acc_data.push_back(avm_m1_writedata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Pulse start for one edge; returns at cycle N+1
  task automatic start(input logic [31:0] base, input logic [29:0] nel);
    sdr_baseaddr   = base;
    sdr_nelems     = nel;
    sdr_writestart = 1'b1;
    tick();
    sdr_writestart = 1'b0;
  endtask

  task automatic clear_log();
    acc_addr.delete();
    acc_data.delete();
  endtask

  initial begin
    int cyc;
    logic [31:0] last_a;
    logic [15:0] last_d;

    sdr_reset          = 1'b1;
    sdr_writestart     = 1'b0;
    sdr_baseaddr       = '0;
    sdr_nelems         = '0;
    sdr_writedata      = '0;
    avm_m1_waitrequest = 1'b0;
    tick();
    chk("rst_write", 32'(avm_m1_write), 32'd0);
    chk("rst_end", 32'(sdr_writeend), 32'd0);
    chk("rst_busy", 32'(sdr_busy), 32'd0);
    chk("rst_be", 32'(avm_m1_byteenable), 32'd0);
    sdr_reset = 1'b0;
    tick();

    // Basic 4-word transfer, no stalls; buffer changed after capture
    clear_log();
    sdr_writedata          = '0;
    sdr_writedata[63:0]    = 64'h0032_0028_001E_0014;
    start(32'h0, 30'd2);
    sdr_writedata = {64{32'hDEAD_BEEF}};
    chk("t1_w0_write", 32'(avm_m1_write), 32'd1);
    chk("t1_w0_addr", avm_m1_address, 32'h0);
    chk("t1_w0_data", 32'(avm_m1_writedata), 32'h0014);
    chk("t1_w0_be", 32'(avm_m1_byteenable), 32'h3);
    chk("t1_w0_busy", 32'(sdr_busy), 32'd1);
    tick();
    chk("t1_w1_addr", avm_m1_address, 32'h2);
    chk("t1_w1_data", 32'(avm_m1_writedata), 32'h001E);
    tick();
    chk("t1_w2_addr", avm_m1_address, 32'h4);
    chk("t1_w2_data", 32'(avm_m1_writedata), 32'h0028);
    tick();
    chk("t1_w3_addr", avm_m1_address, 32'h6);
    chk("t1_w3_data", 32'(avm_m1_writedata), 32'h0032);
    chk("t1_w3_end", 32'(sdr_writeend), 32'd0);
    tick();
    chk("t1_end", 32'(sdr_writeend), 32'd1);
    chk("t1_end_write", 32'(avm_m1_write), 32'd0);
    chk("t1_end_busy", 32'(sdr_busy), 32'd0);
    chk("t1_end_be", 32'(avm_m1_byteenable), 32'd0);
    tick();
    chk("t1_end_hold", 32'(sdr_writeend), 32'd1);
    chk("t1_count", 32'(acc_addr.size()), 32'd4);

    // Same transfer with stalls on words 1 and 3, started from DONE
    clear_log();
    sdr_writedata       = '0;
    sdr_writedata[63:0] = 64'h0032_0028_001E_0014;
    start(32'h0, 30'd2);
    chk("t2_end_fall", 32'(sdr_writeend), 32'd0);
    chk("t2_w0_addr", avm_m1_address, 32'h0);
    tick();
    avm_m1_waitrequest = 1'b1;
    chk("t2_w1_addr_a", avm_m1_address, 32'h2);
    chk("t2_w1_data_a", 32'(avm_m1_writedata), 32'h001E);
    tick();
    chk("t2_w1_addr_b", avm_m1_address, 32'h2);
    chk("t2_w1_write_b", 32'(avm_m1_write), 32'd1);
    tick();
    avm_m1_waitrequest = 1'b0;
    chk("t2_w1_addr_c", avm_m1_address, 32'h2);
    chk("t2_w1_data_c", 32'(avm_m1_writedata), 32'h001E);
    tick();
    chk("t2_w2_addr", avm_m1_address, 32'h4);
    tick();
    avm_m1_waitrequest = 1'b1;
    chk("t2_w3_addr_a", avm_m1_address, 32'h6);
    tick();
    avm_m1_waitrequest = 1'b0;
    chk("t2_w3_addr_b", avm_m1_address, 32'h6);
    chk("t2_w3_end_b", 32'(sdr_writeend), 32'd0);
    tick();
    chk("t2_end", 32'(sdr_writeend), 32'd1);
    chk("t2_end_write", 32'(avm_m1_write), 32'd0);
    chk("t2_count", 32'(acc_addr.size()), 32'd4);
    if (acc_data.size() == 4) begin
      chk("t2_acc_d1", 32'(acc_data[1]), 32'h001E);
      chk("t2_acc_a3", acc_addr[3], 32'h6);
    end

    // Zero elements: straight to DONE, no bus activity
    clear_log();
    start(32'h40, 30'd0);
    chk("t3_end", 32'(sdr_writeend), 32'd1);
    chk("t3_write", 32'(avm_m1_write), 32'd0);
    chk("t3_busy", 32'(sdr_busy), 32'd0);
    tick();
    tick();
    chk("t3_count", 32'(acc_addr.size()), 32'd0);

    // Clamp: 100 elements -> 128 words; halfword i holds value i
    clear_log();
    for (int i = 0; i < 128; i++) sdr_writedata[16*i +: 16] = 16'(i);
    start(32'h1000, 30'd100);
    cyc = 1;
    while (!sdr_writeend && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("t4_end_cycle", 32'(cyc), 32'd129);
    chk("t4_count", 32'(acc_addr.size()), 32'd128);
    last_a = (acc_addr.size() > 0) ? acc_addr[$] : 32'hFFFF_FFFF;
    last_d = (acc_data.size() > 0) ? acc_data[$] : 16'hFFFF;
    chk("t4_last_addr", last_a, 32'h10FE);
    chk("t4_last_data", 32'(last_d), 32'h007F);

    // Address wrap past 2^32
    clear_log();
    sdr_writedata       = '0;
    sdr_writedata[63:0] = 64'h0004_0003_0002_0001;
    start(32'hFFFF_FFFC, 30'd2);
    tick(); tick(); tick(); tick();
    chk("t5_count", 32'(acc_addr.size()), 32'd4);
    if (acc_addr.size() == 4) begin
      chk("t5_a0", acc_addr[0], 32'hFFFF_FFFC);
      chk("t5_a1", acc_addr[1], 32'hFFFF_FFFE);
      chk("t5_a2", acc_addr[2], 32'h0000_0000);
      chk("t5_a3", acc_addr[3], 32'h0000_0002);
    end

    // Reset mid-transfer drops everything asynchronously
    clear_log();
    start(32'h200, 30'd2);
    tick();
    tick();
    chk("t6_pre_addr", avm_m1_address, 32'h204);
    #2;
    sdr_reset = 1'b1;
    #1;
    chk("t6_rst_write", 32'(avm_m1_write), 32'd0);
    chk("t6_rst_busy", 32'(sdr_busy), 32'd0);
    chk("t6_rst_end", 32'(sdr_writeend), 32'd0);
    #2;
    sdr_reset = 1'b0;
    tick();
    chk("t6_idle_write", 32'(avm_m1_write), 32'd0);

    // Restart after reset; a second start during WRITE is ignored
    clear_log();
    start(32'h200, 30'd2);
    sdr_baseaddr   = 32'h800;
    sdr_nelems     = 30'd5;
    sdr_writestart = 1'b1;
    tick();
    sdr_writestart = 1'b0;
    chk("t7_w1_addr", avm_m1_address, 32'h202);
    tick(); tick();
    chk("t7_w3_end", 32'(sdr_writeend), 32'd0);
    tick();
    chk("t7_end", 32'(sdr_writeend), 32'd1);
    chk("t7_count", 32'(acc_addr.size()), 32'd4);
    if (acc_addr.size() == 4) begin
      chk("t7_a0", acc_addr[0], 32'h200);
      chk("t7_d3", 32'(acc_data[3]), 32'h0004);
    end

    // Start from DONE with new base and one element
    clear_log();
    start(32'h100, 30'd1);
    chk("t8_end_fall", 32'(sdr_writeend), 32'd0);
    chk("t8_a0", avm_m1_address, 32'h100);
    chk("t8_d0", 32'(avm_m1_writedata), 32'h0001);
    tick();
    chk("t8_a1", avm_m1_address, 32'h102);
    chk("t8_d1", 32'(avm_m1_writedata), 32'h0002);
    tick();
    chk("t8_end", 32'(sdr_writeend), 32'd1);
    chk("t8_count", 32'(acc_addr.size()), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_sdr_writer.md
Name: avalon_sdr_writer

Overview:
- Avalon-MM write master that streams a wide result buffer from the ray-tracing datapath into SDRAM as 16-bit words.
- It is the write-direction counterpart of the SDRAM read master. Both masters share the same element convention: 32-bit elements, two halfwords each, low halfword first, byte addresses.
- It sits between the raytracer result logic and the SDRAM controller's Avalon-MM slave port.

Parameters:
- DATA_W, 16, Avalon data width in bits (one halfword).
- BUF_W, 2048, width of the sdr_writedata buffer in bits.
- ADDR_W, 32, Avalon byte-address width.
- MAX_ELEMS, BUF_W/32 = 64, maximum number of 32-bit elements per transfer.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- sdr_reset  in  1  asynchronous, active-high reset.
- sdr_writestart  in  1  one-cycle start pulse, sampled in IDLE or DONE.
- sdr_baseaddr  in  ADDR_W  SDRAM byte address of element 0.
- sdr_nelems  in  30  number of 32-bit elements to write.
- sdr_writedata  in  BUF_W  source buffer; element i = bits [32*i +: 32].
- sdr_writeend  out  1  level high while in DONE.
- sdr_busy  out  1  high while in WRITE.
- avm_m1_write  out  1  Avalon write request.
- avm_m1_address  out  ADDR_W  Avalon byte address.
- avm_m1_writedata  out  DATA_W  Avalon write data.
- avm_m1_byteenable  out  2  always 2'b11 when writing, else 2'b00.
- avm_m1_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; internal word index = 0; captured base, count and data cleared.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE or DONE + sdr_writestart=1 at edge N:
  - Capture sdr_baseaddr, sdr_writedata snapshot and word count nw = 2*min(sdr_nelems, MAX_ELEMS).
  - Clear word index k.
  - If nw=0, go to DONE (sdr_writeend high from cycle N+1); otherwise go to WRITE.
  - A new start clears sdr_writeend in the same edge.
- WRITE:
  - Drive avm_m1_write=1, avm_m1_address = base + 2*k (mod 2^ADDR_W), avm_m1_writedata = snapshot[16*k +: 16], avm_m1_byteenable = 2'b11.
  - The first write is asserted in cycle N+1.
- Acceptance: a word is accepted at an edge where avm_m1_write=1 and avm_m1_waitrequest=0. On acceptance, k increments and address/data update on the same edge, giving back-to-back writes with one word per cycle when there is no stall.
- While avm_m1_waitrequest=1: address, data, byteenable and write are held stable.
- Last word (k = nw-1) accepted at edge M: avm_m1_write=0 and sdr_writeend=1 from cycle M+1; state = DONE.
- DONE: sdr_writeend stays high until reset or the next sdr_writestart. No Avalon activity.
- sdr_writestart during WRITE: ignored; the transfer continues with the captured values.
- Changes to sdr_writedata, sdr_baseaddr or sdr_nelems after capture have no effect.
- sdr_nelems > MAX_ELEMS: clamped to MAX_ELEMS (128 words); upper buffer bits beyond BUF_W are never read.
- Address wraps modulo 2^ADDR_W; no error is flagged.
- Reset asserted mid-transfer: avm_m1_write drops asynchronously. The partial transfer is abandoned and is not resumed.
- Throughput: nw-word transfer with no stalls = nw cycles of avm_m1_write, with sdr_writeend at start edge + nw + 1.

Test Plan:
- base=0, nelems=2, buffer low 64 bits=0x0032_0028_001E_0014, waitrequest=0, start pulse at edge N -> writes on cycles N+1..N+4 at addresses 0,2,4,6 with data 0x0014, 0x001E, 0x0028, 0x0032; sdr_writeend=1 from N+5 and remains high.
- Same as above, but waitrequest=1 for 2 cycles during word 1 and 1 cycle during word 3 -> address 2 / data 0x001E held for 3 cycles, address 6 held for 2 cycles; exactly 4 accepted writes; sdr_writeend at N+8.
- nelems=0 -> no avm_m1_write ever asserted; sdr_writeend=1 on N+1. nelems=100 -> exactly 128 writes, last address base+254, then DONE.
- base=0xFFFFFFFC, nelems=2 -> addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000, 0x00000002.
- sdr_reset pulsed during word 2 of 4 -> avm_m1_write, sdr_busy and sdr_writeend are 0 immediately. A new start after reset writes all words again from base. A second sdr_writestart during WRITE -> no restart; the word count is unchanged.
- Start from DONE with new base=0x100, nelems=1 -> sdr_writeend falls at the start edge; 2 writes at 0x100 and 0x102; sdr_writeend rises again.
